// File: rtl/gpio_irq_ctrl.sv
// GPIO edge-interrupt controller: debounce, edge detect, pending latch, irq.
// Optional per-bit debounce counters enabled by macro GPIO_IRQ_DEBOUNCE_EN.
//
// Ports:
//   clk_i      clock, all state on rising edge
//   reset_i    synchronous active-high reset
//   pin_i      synchronised port value
//   rise_en_i  per-bit rising-edge event enable
//   fall_en_i  per-bit falling-edge event enable
//   mask_i     per-bit interrupt enable
//   clr_we_i   write strobe for clr_i
//   clr_i      write-1-to-clear pattern for pending bits
//   stable_o   accepted (filtered) pin level
//   pending_o  latched edge events
//   irq_o      registered interrupt request
module gpio_irq_ctrl #(
  parameter int WIDTH_PORT      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [WIDTH_PORT-1:0] pin_i,
  input  logic [WIDTH_PORT-1:0] rise_en_i,
  input  logic [WIDTH_PORT-1:0] fall_en_i,
  input  logic [WIDTH_PORT-1:0] mask_i,
  input  logic                  clr_we_i,
  input  logic [WIDTH_PORT-1:0] clr_i,
  output logic [WIDTH_PORT-1:0] stable_o,
  output logic [WIDTH_PORT-1:0] pending_o,
  output logic                  irq_o
);

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [WIDTH_PORT-1:0] stable_q, stable_d;
  logic [WIDTH_PORT-1:0] prev_q, prev_d;
  logic [WIDTH_PORT-1:0] pending_q, pending_d;
  logic                  irq_q, irq_d;
  logic [WIDTH_PORT-1:0] rise, fall, clr_m;

  assign rise  = stable_q & ~prev_q & rise_en_i;
  assign fall  = ~stable_q & prev_q & fall_en_i;
  assign clr_m = clr_we_i ? clr_i : '0;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q [WIDTH_PORT];
  logic [CW-1:0] cnt_d [WIDTH_PORT];
`else
  logic unused_db;
  assign unused_db = (DEBOUNCE_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    prev_d    = prev_q;
    pending_d = pending_q;
    // irq lags pending by one edge; mask changes show up next edge
    irq_d     = |(pending_q & mask_i);
`ifdef GPIO_IRQ_DEBOUNCE_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      INIT: begin
        // prev == stable here, so a pin already high raises no event
        stable_d = pin_i;
        prev_d   = pin_i;
        state_d  = RUN;
`ifdef GPIO_IRQ_DEBOUNCE_EN
        for (int b = 0; b < WIDTH_PORT; b++) cnt_d[b] = '0;
`endif
      end
      RUN: begin
        prev_d    = stable_q;
        // set wins over clear so an event is never lost
        pending_d = (pending_q & ~clr_m) | rise | fall;
`ifdef GPIO_IRQ_DEBOUNCE_EN
        for (int b = 0; b < WIDTH_PORT; b++) begin
          if (pin_i[b] != stable_q[b]) begin
            if (cnt_q[b] == CMAX) begin
              stable_d[b] = pin_i[b];
              cnt_d[b]    = '0;
            end else begin
              cnt_d[b] = cnt_q[b] + 1'b1;
            end
          end else begin
            cnt_d[b] = '0;
          end
        end
`else
        stable_d = pin_i;
`endif
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= INIT;
      stable_q  <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      cnt_q     <= '{default: '0};
`endif
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign stable_o  = stable_q;
  assign pending_o = pending_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl (WIDTH_PORT=8, DEBOUNCE_CYCLES=4).
// Works with or without GPIO_IRQ_DEBOUNCE_EN defined.
module tb_gpio_irq_ctrl;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] pin, rise_en, fall_en, mask, clr;
  logic       clr_we;
  logic [7:0] stable_o, pending_o;
  logic       irq_o;

  int n_vec = 0;
  int n_err = 0;

  gpio_irq_ctrl #(
    .WIDTH_PORT     (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .pin_i    (pin),
    .rise_en_i(rise_en),
    .fall_en_i(fall_en),
    .mask_i   (mask),
    .clr_we_i (clr_we),
    .clr_i    (clr),
    .stable_o (stable_o),
    .pending_o(pending_o),
    .irq_o    (irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level is accepted once it has differed from
  // the accepted level for DEB consecutive samples; an accepted change
  // shows as an event one edge later, irq one edge after that.
  logic       m_valid = 1'b0;
  logic       m_init;
  logic [7:0] m_stable, m_prev, m_pend;
  logic       m_irq;
  int         run_len [8];

  always @(posedge clk) begin : model
    logic [7:0] ev;
    if (reset) begin
      m_init = 1'b1;
      m_stable = '0;
      m_prev = '0;
      m_pend = '0;
      m_irq = 1'b0;
      for (int b = 0; b < 8; b++) run_len[b] = 0;
    end else if (m_init) begin
      m_irq = |(m_pend & mask);
      m_stable = pin;
      m_prev = pin;
      m_init = 1'b0;
      for (int b = 0; b < 8; b++) run_len[b] = 0;
    end else begin
      m_irq = |(m_pend & mask);
      ev = (m_stable & ~m_prev & rise_en) | (~m_stable & m_prev & fall_en);
      m_prev = m_stable;
      m_pend = (m_pend & ~(clr_we ? clr : 8'h00)) | ev;
      for (int b = 0; b < 8; b++) begin
        if (pin[b] != m_stable[b]) begin
          run_len[b] = run_len[b] + 1;
          if (run_len[b] == DEB) begin
            m_stable[b] = pin[b];
            run_len[b] = 0;
          end
        end else begin
          run_len[b] = 0;
        end
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_stable", stable_o, m_stable);
      chk("mdl_pending", pending_o, m_pend);
      chk("mdl_irq", {7'd0, irq_o}, {7'd0, m_irq});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    clr_we = 1'b1;
    clr = 8'hFF;
    step(1);
    clr_we = 1'b0;
    clr = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    pin = 8'hFF;
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    mask = 8'hFF;
    clr_we = 1'b0;
    clr = 8'h00;
    step(2);
    chk("rst_stable", stable_o, 8'h00);
    chk("rst_pending", pending_o, 8'h00);
    chk("rst_irq", {7'd0, irq_o}, 8'h00);

    // high pins through reset release: no spurious events
    reset = 1'b0;
    step(1);
    chk("init_stable", stable_o, 8'hFF);
    step(DEB + 3);
    chk("init_pending", pending_o, 8'h00);
    chk("init_irq", {7'd0, irq_o}, 8'h00);

    rise_en = 8'h00;
    fall_en = 8'h00;
    pin = 8'h00;
    step(DEB + 3);
    chk("low_stable", stable_o, 8'h00);

    // bit0 rising edge with irq
    rise_en = 8'h01;
    mask = 8'h01;
    pin = 8'h01;
    step(DEB - 1);
    chk("rise_pre", stable_o, 8'h00);
    step(1);
    chk("rise_stable", stable_o, 8'h01);
    chk("rise_pend0", pending_o, 8'h00);
    step(1);
    chk("rise_pend1", pending_o, 8'h01);
    chk("rise_irq0", {7'd0, irq_o}, 8'h00);
    step(1);
    chk("rise_irq1", {7'd0, irq_o}, 8'h01);

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // 3-sample glitch on bit1 is filtered
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin = 8'h03;
    step(3);
    pin = 8'h01;
    step(6);
    chk("glitch_stable", stable_o, 8'h01);
    chk("glitch_pend", pending_o, 8'h01);
`endif

    clear_all();
    chk("clr_all", pending_o, 8'h00);
    step(1);

    // write-1-to-clear and set-beats-clear
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin = 8'h02;
    step(DEB + 2);
    chk("w1c_pend3", pending_o, 8'h03);
    clr_we = 1'b1;
    clr = 8'h01;
    step(1);
    clr_we = 1'b0;
    chk("w1c_pend2", pending_o, 8'h02);
    pin = 8'h00;
    step(DEB);
    clr_we = 1'b1;
    clr = 8'h02;
    step(1);
    chk("set_wins", pending_o, 8'h02);
    step(1);
    clr_we = 1'b0;
    chk("clr_bit1", pending_o, 8'h00);

    // mask only gates irq
    mask = 8'h00;
    pin = 8'h04;
    step(DEB + 2);
    chk("msk_pend", pending_o, 8'h04);
    chk("msk_irq0", {7'd0, irq_o}, 8'h00);
    mask = 8'h04;
    step(1);
    chk("msk_irq1", {7'd0, irq_o}, 8'h01);
    chk("msk_pend_keep", pending_o, 8'h04);
    mask = 8'h00;
    step(1);
    chk("msk_irq_off", {7'd0, irq_o}, 8'h00);

    // reset in the middle of a debounce
    pin = 8'h84;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    chk("rstmid_stable", stable_o, 8'h84);
    step(DEB + 2);
    chk("rstmid_pend", pending_o, 8'h00);
    chk("rstmid_irq", {7'd0, irq_o}, 8'h00);

    // single-bit rise on bit7
    pin = 8'h00;
    step(DEB + 3);
    clear_all();
    rise_en = 8'h80;
    fall_en = 8'h00;
    pin = 8'h80;
    step(DEB);
    chk("b7_stable", stable_o, 8'h80);
    chk("b7_pend0", pending_o, 8'h00);
    step(1);
    chk("b7_pend1", pending_o, 8'h80);

    // mixed traffic checked against the model
    for (int i = 0; i < 60; i++) begin
      pin = 8'($urandom);
      rise_en = 8'($urandom);
      fall_en = 8'($urandom);
      mask = 8'($urandom);
      clr = 8'($urandom);
      clr_we = ($urandom_range(0, 3) == 0);
      step($urandom_range(1, 7));
    end
    clr_we = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
